// File: rtl/shr_seq_pkg.sv
// Shared types and counter sizing for the shift-register sequence generator.
// The FSM state encoding lives here so the top and any checkers agree on it.
package shr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    SYNC  = 3'd4,
    GAP   = 3'd5
  } state_t;

  // Bits needed to hold n_values distinct counter values, never less than one.
  function automatic int cnt_w(input int n_values);
    return (n_values > 1) ? $clog2(n_values) : 1;
  endfunction

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLR_LEN = 8;

  localparam int DEF_DIV_W = cnt_w(2 * DEF_CLK_DIV);
  localparam int DEF_BIT_W = cnt_w(DEF_WIDTH);
  localparam int DEF_CLR_W = cnt_w(DEF_CLR_LEN);

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous control input, with an optional
// registered rising-edge pulse output.
module sync_edge
  import shr_seq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;
  logic stable;
  logic prev;
  logic pulse;

  // Synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= din;
      stable <= meta;
      prev   <= stable;
      pulse  <= stable & ~prev;
    end
  end

  assign dout = EDGE ? pulse : stable;

endmodule

// File: rtl/shr_seq_gen.sv
// Serial frame generator for external shift-register chips: clear strobe,
// parallel-load, MSB-first shifting on a divided sclk, sync strobe and gap.
module shr_seq_gen
  import shr_seq_pkg::*;
#(
  parameter int N_CH    = 1,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CLR_LEN = DEF_CLR_LEN
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    trig,
  input  logic                    dump,
  input  logic                    clr,
  input  logic [N_CH*WIDTH-1:0]   data_in,
  output logic                    sclk,
  output logic [N_CH-1:0]         sdin,
  output logic                    syn,
  output logic                    wclr,
  output logic                    out_en,
  output logic                    clk_out_en,
  output logic                    busy,
  output logic                    done
);

  localparam int DIV_W = cnt_w(2 * CLK_DIV);
  localparam int BIT_W = cnt_w(WIDTH);
  localparam int CLR_W = cnt_w(CLR_LEN);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WIDTH - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_LEN - 1);

  logic trig_p;
  logic dump_s;
  logic clr_p;

  state_t                       state;
  state_t                       state_nxt;
  logic [DIV_W-1:0]             div_cnt;
  logic [DIV_W-1:0]             div_nxt;
  logic [BIT_W-1:0]             bit_idx;
  logic [BIT_W-1:0]             bit_nxt;
  logic [CLR_W-1:0]             clr_cnt;
  logic [CLR_W-1:0]             clr_nxt;
  logic                         pending;
  logic                         pending_nxt;
  logic [N_CH-1:0][WIDTH-1:0]   shadow;
  logic [N_CH-1:0][WIDTH-1:0]   shadow_nxt;
  logic [N_CH-1:0]              sdin_nxt;

  sync_edge #(.EDGE(1'b1)) u_trig_sync (
    .clk  (clk_in),
    .rst  (rst),
    .din  (trig),
    .dout (trig_p)
  );

  sync_edge #(.EDGE(1'b0)) u_dump_sync (
    .clk  (clk_in),
    .rst  (rst),
    .din  (dump),
    .dout (dump_s)
  );

  sync_edge #(.EDGE(1'b1)) u_clr_sync (
    .clk  (clk_in),
    .rst  (rst),
    .din  (clr),
    .dout (clr_p)
  );

  // Next-state, counter and shadow-register logic.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    bit_nxt     = bit_idx;
    clr_nxt     = clr_cnt;
    pending_nxt = pending;
    shadow_nxt  = shadow;
    case (state)
      IDLE: begin
        if (clr_p) begin
          // A trig arriving together with clr is remembered and served after CLEAR.
          state_nxt   = CLEAR;
          clr_nxt     = {CLR_W{1'b0}};
          pending_nxt = trig_p;
        end else if (trig_p || dump_s) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          pending_nxt = 1'b0;
          state_nxt   = (pending || dump_s) ? LOAD : IDLE;
        end else begin
          clr_nxt = clr_cnt + CLR_W'(1);
        end
      end
      LOAD: begin
        shadow_nxt = data_in;
        div_nxt    = {DIV_W{1'b0}};
        bit_nxt    = BIT_TOP;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = {DIV_W{1'b0}};
          if (bit_idx == {BIT_W{1'b0}}) begin
            state_nxt = SYNC;
          end else begin
            bit_nxt = bit_idx - BIT_W'(1);
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      SYNC: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = {DIV_W{1'b0}};
          state_nxt = GAP;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = {DIV_W{1'b0}};
          state_nxt = dump_s ? LOAD : IDLE;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial data is looked up from the next-cycle bit index so it lines up with sclk.
  for (genvar g = 0; g < N_CH; g++) begin : g_sdin
    assign sdin_nxt[g] = (state_nxt == SHIFT) ? shadow_nxt[g][bit_nxt] : 1'b0;
  end

  // FSM, counters and data shadow register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= {DIV_W{1'b0}};
      bit_idx <= {BIT_W{1'b0}};
      clr_cnt <= {CLR_W{1'b0}};
      pending <= 1'b0;
      shadow  <= {(N_CH*WIDTH){1'b0}};
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_idx <= bit_nxt;
      clr_cnt <= clr_nxt;
      pending <= pending_nxt;
      shadow  <= shadow_nxt;
    end
  end

  // Registered pin outputs; busy follows the state one cycle behind.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk       <= 1'b0;
      sdin       <= {N_CH{1'b0}};
      syn        <= 1'b0;
      wclr       <= 1'b0;
      out_en     <= 1'b0;
      clk_out_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sclk       <= (state_nxt == SHIFT) && (div_nxt >= DIV_HALF);
      sdin       <= sdin_nxt;
      syn        <= (state_nxt == SYNC);
      wclr       <= (state_nxt == CLEAR);
      out_en     <= (state_nxt == SHIFT) || (state_nxt == SYNC);
      clk_out_en <= (state_nxt == SHIFT);
      busy       <= (state != IDLE);
      done       <= (state_nxt == GAP) && (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: tb/tb_shr_seq_gen.sv
// Self-checking bench for shr_seq_gen: two instances (2x8 bit, div 2 and
// 1x2 bit, div 1) compared cycle by cycle against a frame-timing model.
module tb_shr_seq_gen;

  typedef struct packed {
    logic       sclk;
    logic [1:0] sdin;
    logic       syn;
    logic       out_en;
    logic       clk_out_en;
    logic       done;
  } obs_t;

  localparam int FA = 1 + 2 * 2 * (8 + 2);
  localparam int FB = 1 + 2 * 1 * (2 + 2);

  logic clk = 1'b0;
  logic rst;

  logic        trig_a = 1'b0, dump_a = 1'b0, clr_a = 1'b0;
  logic [15:0] data_a = 16'h0000;
  logic        sclk_a, syn_a, wclr_a, out_en_a, clk_out_en_a, busy_a, done_a;
  logic [1:0]  sdin_a;

  logic        trig_b = 1'b0, dump_b = 1'b0, clr_b = 1'b0;
  logic [1:0]  data_b = 2'b00;
  logic        sclk_b, syn_b, wclr_b, out_en_b, clk_out_en_b, busy_b, done_b;
  logic [0:0]  sdin_b;

  int n_checks = 0;
  int n_fail   = 0;

  shr_seq_gen #(.N_CH(2), .WIDTH(8), .CLK_DIV(2), .CLR_LEN(8)) dut_a (
    .clk_in(clk), .rst(rst), .trig(trig_a), .dump(dump_a), .clr(clr_a),
    .data_in(data_a), .sclk(sclk_a), .sdin(sdin_a), .syn(syn_a), .wclr(wclr_a),
    .out_en(out_en_a), .clk_out_en(clk_out_en_a), .busy(busy_a), .done(done_a)
  );

  shr_seq_gen #(.N_CH(1), .WIDTH(2), .CLK_DIV(1), .CLR_LEN(4)) dut_b (
    .clk_in(clk), .rst(rst), .trig(trig_b), .dump(dump_b), .clr(clr_b),
    .data_in(data_b), .sclk(sclk_b), .sdin(sdin_b), .syn(syn_b), .wclr(wclr_b),
    .out_en(out_en_b), .clk_out_en(clk_out_en_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Expected pins t cycles after the LOAD cycle (t=0) of one frame.
  function automatic obs_t model(input int t, input int n, input int w, input int d,
                                 input logic [15:0] data);
    obs_t e;
    int shift_len, j, b;
    e = '0;
    shift_len = 2 * d * w;
    if (t >= 1 && t <= shift_len) begin
      j = t - 1;
      b = w - 1 - j / (2 * d);
      e.sclk = ((j % (2 * d)) >= d);
      for (int c = 0; c < n; c++) e.sdin[c] = data[c * w + b];
      e.out_en = 1'b1;
      e.clk_out_en = 1'b1;
    end else if (t > shift_len && t <= shift_len + 2 * d) begin
      e.syn = 1'b1;
      e.out_en = 1'b1;
    end else if (t == shift_len + 4 * d) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t obs_a();
    return {sclk_a, sdin_a, syn_a, out_en_a, clk_out_en_a, done_a};
  endfunction

  function automatic obs_t obs_b();
    return {sclk_b, 1'b0, sdin_b, syn_b, out_en_b, clk_out_en_b, done_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({obs_a(), wclr_a, busy_a, obs_b(), wclr_b, busy_b} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=0", {obs_a(), wclr_a, busy_a, obs_b(), wclr_b, busy_b});
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    n_checks++;
    if ({obs_a(), wclr_a, busy_a, obs_b(), wclr_b, busy_b} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=0", {obs_a(), wclr_a, busy_a, obs_b(), wclr_b, busy_b});
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] vals [2];
    logic [31:0] r;
    obs_t e;
    r = $urandom;
    vals[0] = 16'hA53C;
    vals[1] = r[15:0];
    for (int v = 0; v < 2; v++) begin
      data_a = vals[v];
      trig_a = 1'b1;
      repeat (4) tick();
      for (int t = 0; t <= FA + 1; t++) begin
        if (t == 2) trig_a = 1'b0;
        e = model(t, 2, 8, 2, vals[v]);
        n_checks++;
        if (obs_a() !== e) begin
          n_fail++;
          $display("FAIL frame_pins data=%h t=%0d got=%b exp=%b", vals[v], t, obs_a(), e);
        end
        n_checks++;
        if ({busy_a, wclr_a} !== {(t >= 1 && t <= FA), 1'b0}) begin
          n_fail++;
          $display("FAIL frame_busy data=%h t=%0d got=%b exp=%b", vals[v], t,
                   {busy_a, wclr_a}, {(t >= 1 && t <= FA), 1'b0});
        end
        tick();
      end
      repeat (4) tick();
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [31:0] r;
    r = $urandom;
    data_a = r[15:0];
    trig_a = 1'b1;
    repeat (4) tick();
    trig_a = 1'b0;
    repeat (18) tick();
    n_checks++;
    if (clk_out_en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_in_shift got=%b exp=1", clk_out_en_a);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({obs_a(), wclr_a, busy_a} !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async got=%b exp=0", {obs_a(), wclr_a, busy_a});
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({obs_a(), wclr_a, busy_a} !== 9'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc=%0d got=%b exp=0", i, {obs_a(), wclr_a, busy_a});
      end
    end
    trig_a = 1'b1;
    repeat (5) tick();
    trig_a = 1'b0;
    n_checks++;
    if ({busy_a, clk_out_en_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset_retrig got=%b exp=11", {busy_a, clk_out_en_a});
    end
    repeat (FA + 4) tick();
  endtask

  task automatic test_clear_priority();
    logic [31:0] r;
    obs_t e;
    r = $urandom;
    data_a = r[15:0];
    trig_a = 1'b1;
    clr_a  = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        trig_a = 1'b0;
        clr_a  = 1'b0;
      end
      n_checks++;
      if ({wclr_a, clk_out_en_a, syn_a} !== 3'b100) begin
        n_fail++;
        $display("FAIL clear_phase cyc=%0d got=%b exp=100", i, {wclr_a, clk_out_en_a, syn_a});
      end
      tick();
    end
    for (int t = 0; t <= FA + 1; t++) begin
      e = model(t, 2, 8, 2, r[15:0]);
      n_checks++;
      if (obs_a() !== e || wclr_a !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_frame t=%0d got=%b/%b exp=%b/0", t, obs_a(), wclr_a, e);
      end
      if (t >= 1) begin
        n_checks++;
        if (busy_a !== (t <= FA)) begin
          n_fail++;
          $display("FAIL clear_busy t=%0d got=%b exp=%b", t, busy_a, (t <= FA));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [15:0] d1, d2, dat;
    obs_t e;
    int g, dones, f, t;
    bit found;
    r = $urandom;
    d1 = r[15:0];
    d2 = ~d1;
    data_a = d1;
    dump_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (clk_out_en_a === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL dump_start got=timeout exp=shift within 20 cycles");
      dump_a = 1'b0;
      return;
    end
    dones = 0;
    for (g = 1; g <= 3 * FA + 10; g++) begin
      if (g == FA + 5) data_a = d2;
      if (g == 2 * FA + 5) dump_a = 1'b0;
      f = g / FA;
      t = (g >= 3 * FA) ? FA + g - 3 * FA : g % FA;
      dat = (f < 2) ? d1 : d2;
      e = model(t, 2, 8, 2, dat);
      n_checks++;
      if (obs_a() !== e || busy_a !== (g <= 3 * FA)) begin
        n_fail++;
        $display("FAIL dump_frames g=%0d got=%b/%b exp=%b/%b", g, obs_a(), busy_a, e, (g <= 3 * FA));
      end
      if (done_a === 1'b1) dones++;
      tick();
    end
    n_checks++;
    if (dones != 3) begin
      n_fail++;
      $display("FAIL dump_done_count got=%0d exp=3", dones);
    end
  endtask

  task automatic test_trig_ignored();
    logic [31:0] r;
    obs_t e;
    int dones;
    r = $urandom;
    data_a = r[15:0];
    dones = 0;
    trig_a = 1'b1;
    repeat (4) tick();
    for (int t = 0; t <= FA + 30; t++) begin
      if (t == 2 || t == 8 || t == 39) trig_a = 1'b0;
      if (t == 5 || t == 37) trig_a = 1'b1;
      e = model(t, 2, 8, 2, r[15:0]);
      n_checks++;
      if (obs_a() !== e || (t >= 1 && busy_a !== (t <= FA))) begin
        n_fail++;
        $display("FAIL trig_ignored t=%0d got=%b/%b exp=%b/%b", t, obs_a(), busy_a, e, (t <= FA));
      end
      if (done_a === 1'b1) dones++;
      tick();
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL trig_ignored_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_min_config();
    logic [1:0] vals [2];
    obs_t e;
    vals[0] = 2'b10;
    vals[1] = 2'b01;
    for (int v = 0; v < 2; v++) begin
      data_b = vals[v];
      trig_b = 1'b1;
      repeat (4) tick();
      for (int t = 0; t <= FB + 1; t++) begin
        if (t == 2) trig_b = 1'b0;
        e = model(t, 1, 2, 1, {14'd0, vals[v]});
        n_checks++;
        if (obs_b() !== e || wclr_b !== 1'b0) begin
          n_fail++;
          $display("FAIL min_frame data=%b t=%0d got=%b exp=%b", vals[v], t, obs_b(), e);
        end
        if (t >= 1) begin
          n_checks++;
          if (busy_b !== (t <= FB)) begin
            n_fail++;
            $display("FAIL min_busy data=%b t=%0d got=%b exp=%b", vals[v], t, busy_b, (t <= FB));
          end
        end
        tick();
      end
      repeat (3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_mid_frame_reset();
    test_clear_priority();
    test_back_to_back();
    test_trig_ignored();
    test_min_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
